// File: rtl/uart_rdata_sender.sv
// Formats a latched 64-bit dump word (or 32-bit PC) as ASCII hex + CR LF into the UART TX FIFO.
// Latency: first byte the cycle after start; flushing_wq 20 (data) / 11 (PC) cycles after start without stalls.
// Backpressure: tx_fifo_full holds state, counter and tx_wdata; each full cycle delays the rest by one cycle.
module uart_rdata_sender #(
    parameter bit HEX_UPPER = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    input  logic        tx_fifo_full,
    output logic [7:0]  tx_wdata,
    output logic        tx_wen,
    output logic        flushing_wq,
    output logic        snd_busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEX0 = 3'd1,
        SEP  = 3'd2,
        HEX1 = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5,
        DONE = 3'd6
    } state_t;

    // Offset added to nibbles 10..15 so that 10 lands on 'A' (0x41) or 'a' (0x61).
    localparam logic [7:0] ALPHA_BASE = HEX_UPPER ? 8'h37 : 8'h57;

    state_t      state;
    logic [2:0]  cnt;
    logic [63:0] shift_reg;
    logic        mode;

    logic        emitting;
    logic [31:0] cur_word;
    logic [2:0]  nib_idx;
    logic [3:0]  nib;
    logic [7:0]  hex_char;

    // Select the word and nibble being printed (most significant nibble first) and map it to ASCII.
    always_comb begin
        emitting = (state == HEX0) || (state == SEP) || (state == HEX1) ||
                   (state == CR)   || (state == LF);
        cur_word = (state == HEX1) ? shift_reg[63:32] : shift_reg[31:0];
        nib_idx  = 3'd7 - cnt;
        nib      = cur_word[{nib_idx, 2'b00} +: 4];
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (ALPHA_BASE + {4'h0, nib});
    end

    // Byte presented to the FIFO and its write strobe, both purely from current state and fullness.
    always_comb begin
        tx_wen   = emitting && !tx_fifo_full;
        tx_wdata = 8'h00;
        case (state)
            HEX0, HEX1: tx_wdata = hex_char;
            SEP:        tx_wdata = 8'h20;
            CR:         tx_wdata = 8'h0D;
            LF:         tx_wdata = 8'h0A;
            default:    tx_wdata = 8'h00;
        endcase
    end

    // Line sequencer: captures on start, advances only on accepted bytes, pulses flushing_wq at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            shift_reg   <= 64'd0;
            mode        <= 1'b0;
            flushing_wq <= 1'b0;
            snd_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flushing_wq <= 1'b0;
                    if (rdata_snd_start) begin
                        shift_reg <= rdata_snd;
                        mode      <= pc_print_sel;
                        cnt       <= 3'd0;
                        snd_busy  <= 1'b1;
                        state     <= HEX0;
                    end
                end
                HEX0: begin
                    if (tx_wen) begin
                        // The 3-bit counter wraps 7 -> 0 exactly as the state moves on.
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= mode ? CR : SEP;
                        end
                    end
                end
                SEP: begin
                    if (tx_wen) begin
                        cnt   <= 3'd0;
                        state <= HEX1;
                    end
                end
                HEX1: begin
                    if (tx_wen) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= CR;
                        end
                    end
                end
                CR: begin
                    if (tx_wen) begin
                        state <= LF;
                    end
                end
                LF: begin
                    if (tx_wen) begin
                        flushing_wq <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // A start arriving here is dropped; the dump logic waits for flushing_wq.
                    flushing_wq <= 1'b0;
                    snd_busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    flushing_wq <= 1'b0;
                    snd_busy    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Bench for uart_rdata_sender: lower- and upper-case instances driven in parallel.
// Each line's expected byte stream is built from the value; outputs are checked every cycle.
// Directed scenarios first, then randomized lines with random backpressure and stray starts.
module tb_uart_rdata_sender;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] rdata;
    logic        sel;
    logic        full;

    logic [7:0]  wdata_lo, wdata_up;
    logic        wen_lo, wen_up;
    logic        flush_lo, flush_up;
    logic        busy_lo, busy_up;

    int compared;
    int mismatched;

    uart_rdata_sender #(.HEX_UPPER(1'b0)) dut_lo (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdata_snd_start (start),
        .rdata_snd       (rdata),
        .pc_print_sel    (sel),
        .tx_fifo_full    (full),
        .tx_wdata        (wdata_lo),
        .tx_wen          (wen_lo),
        .flushing_wq     (flush_lo),
        .snd_busy        (busy_lo)
    );

    uart_rdata_sender #(.HEX_UPPER(1'b1)) dut_up (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdata_snd_start (start),
        .rdata_snd       (rdata),
        .pc_print_sel    (sel),
        .tx_fifo_full    (full),
        .tx_wdata        (wdata_up),
        .tx_wen          (wen_up),
        .flushing_wq     (flush_up),
        .snd_busy        (busy_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ASCII for one nibble value.
    function automatic logic [7:0] hexc(input int n, input bit upper);
        if (n < 10) return 8'(48 + n);
        return upper ? 8'(65 + n - 10) : 8'(97 + n - 10);
    endfunction

    // Full text of one line: word0 hex, [space, word1 hex,] CR LF.
    function automatic bq_t make_line(input logic [63:0] d, input logic pc, input bit upper);
        bq_t q;
        logic [31:0] w;
        for (int wi = 0; wi < (pc ? 1 : 2); wi++) begin
            w = (wi == 0) ? d[31:0] : d[63:32];
            for (int k = 7; k >= 0; k--) q.push_back(hexc(int'((w >> (4 * k)) & 32'hF), upper));
            if (wi == 0 && !pc) q.push_back(8'h20);
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wen_lo"},   64'(wen_lo),   64'd0);
        check({tag, "_wen_up"},   64'(wen_up),   64'd0);
        check({tag, "_flush_lo"}, 64'(flush_lo), 64'd0);
        check({tag, "_flush_up"}, 64'(flush_up), 64'd0);
        check({tag, "_busy_lo"},  64'(busy_lo),  64'd0);
        check({tag, "_busy_up"},  64'(busy_up),  64'd0);
    endtask

    // bp_mode: 0 none, 1 full on cycles 3-5, 2 random.
    // restart_at: cycle of a stray start during the line, -2 = stray start on the DONE cycle, -1 = none.
    // rst_at: cycle at which reset is asserted mid-line (-1 = never).
    task automatic send_line(input logic [63:0] d, input logic pc, input int bp_mode,
                             input int restart_at, input int rst_at);
        bq_t lo, up;
        int  idx;
        int  cyc;
        lo  = make_line(d, pc, 1'b0);
        up  = make_line(d, pc, 1'b1);
        idx = 0;
        cyc = 1;

        // Cycle 0: start sampled at the end of this cycle.
        @(negedge clk);
        rdata = d; sel = pc; start = 1'b1; full = 1'($urandom_range(0, 1));
        #1;
        check_all_zero("idle_before_start");

        while (idx < lo.size()) begin
            @(negedge clk);
            start = (cyc == restart_at);
            rdata = {$urandom, $urandom};
            sel   = 1'($urandom_range(0, 1));
            case (bp_mode)
                1:       full = (cyc >= 3 && cyc <= 5);
                2:       full = ($urandom_range(0, 3) == 0);
                default: full = 1'b0;
            endcase
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_midline");
                @(negedge clk);
                check_all_zero("rst_held");
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            #1;
            check("wen_lo",   64'(wen_lo),   64'(!full));
            check("wen_up",   64'(wen_up),   64'(!full));
            check("wdata_lo", 64'(wdata_lo), 64'(lo[idx]));
            check("wdata_up", 64'(wdata_up), 64'(up[idx]));
            check("busy_lo",  64'(busy_lo),  64'd1);
            check("flush_lo", 64'(flush_lo), 64'd0);
            if (bp_mode == 1 && cyc == 6) begin
                check("bp_release_wen",   64'(wen_lo),   64'd1);
                check("bp_release_wdata", 64'(wdata_lo), 64'h32);
            end
            if (!full) idx++;
            cyc++;
        end

        // DONE cycle: one-cycle flush pulse, no write even with the FIFO free.
        @(negedge clk);
        start = (restart_at == -2);
        full  = 1'b0;
        #1;
        check("done_flush_lo", 64'(flush_lo), 64'd1);
        check("done_flush_up", 64'(flush_up), 64'd1);
        check("done_busy_lo",  64'(busy_lo),  64'd1);
        check("done_wen_lo",   64'(wen_lo),   64'd0);

        // Back in IDLE; a start on the DONE cycle must not have restarted anything.
        @(negedge clk);
        start = 1'b0;
        full  = 1'($urandom_range(0, 1));
        #1;
        check_all_zero("idle_after");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0; start = 1'b0; rdata = 64'd0; sel = 1'b0; full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        check("reset_wdata_lo", 64'(wdata_lo), 64'd0);
        check("reset_wdata_up", 64'(wdata_up), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_line(64'h89ABCDEF_01234567, 1'b0, 0, -1, -1);
        send_line(64'hFFFF_FFFF_0000_1A2C, 1'b1, 0, -1, -1);
        send_line(64'h89ABCDEF_01234567, 1'b0, 1, -1, -1);
        send_line(64'h89ABCDEF_01234567, 1'b0, 0, 8, -1);
        send_line(64'hFEDCBA98_76543210, 1'b0, 0, -2, -1);
        send_line(64'h89ABCDEF_01234567, 1'b0, 0, -1, 10);
        send_line(64'h0123_4567_89AB_CDEF, 1'b0, 0, -1, -1);

        for (int i = 0; i < 12; i++) begin
            send_line({$urandom, $urandom}, 1'($urandom_range(0, 1)), 2,
                      ($urandom_range(0, 2) == 0) ? -2 : int'($urandom_range(1, 12)), -1);
        end
        send_line({$urandom, $urandom}, 1'b1, 2, -1, int'($urandom_range(2, 8)));
        send_line({$urandom, $urandom}, 1'b0, 2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rdata_sender.md
Name: uart_rdata_sender

Overview:
- Transmit-side partner of the UART monitor dump logic.
- On rdata_snd_start it latches the 64-bit dump word, or the 32-bit PC when pc_print_sel is high.
- It formats the latched value as ASCII hex followed by CR LF and pushes one byte per cycle into the UART transmit FIFO, honouring backpressure.
- When the line is complete it pulses flushing_wq so the dump sequencer can fetch the next pair of words.

Parameters:
- HEX_UPPER, 0, 1 = hex digits a-f emitted as 'A'-'F' (0x41-0x46); 0 = 'a'-'f' (0x61-0x66).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rdata_snd_start  input  1  one-cycle start pulse from the dump logic
- rdata_snd  input  64  payload: {word1[63:32], word0[31:0]}; PC in [31:0]
- pc_print_sel  input  1  sampled with start; 1 = PC line (word0 only)
- tx_fifo_full  input  1  UART TX FIFO cannot accept a byte this cycle
- tx_wdata  output  8  ASCII byte to the FIFO
- tx_wen  output  1  FIFO write strobe; byte accepted when high
- flushing_wq  output  1  one-cycle pulse: line fully queued
- snd_busy  output  1  high from the cycle after start until the flushing_wq pulse, inclusive

Behaviour:
- Reset values: all outputs 0; state IDLE; latched data 0; nibble counter 0.
- Start capture:
  - In IDLE, rdata_snd_start latches rdata_snd into shift_reg[63:0] and pc_print_sel into mode.
  - Next state is HEX with nibble counter 0.
  - rdata_snd_start outside IDLE is ignored; no queuing.
- Character order, data mode (19 bytes): word0 nibbles 7..0, 0x20 (space), word1 nibbles 7..0, 0x0D, 0x0A.
- Character order, PC mode (10 bytes): word0 nibbles 7..0, 0x0D, 0x0A.
- Nibble to ASCII:
  - 0-9 map to 0x30-0x39.
  - 10-15 map to 0x61-0x66, or 0x41-0x46 when HEX_UPPER=1.
- States: IDLE, HEX0, SEP, HEX1, CR, LF, DONE.
  - HEX0: emits word0 nibble (7 - cnt). After cnt 7: goes to SEP in data mode, CR in PC mode.
  - SEP: emits 0x20, then HEX1 with cnt cleared.
  - HEX1: emits word1 nibble (7 - cnt). After cnt 7: goes to CR.
  - CR: emits 0x0D, then LF.
  - LF: emits 0x0A, then DONE.
  - DONE: flushing_wq=1 for exactly one cycle, then IDLE.
- Handshake:
  - In any emitting state, tx_wen = ~tx_fifo_full.
  - tx_wdata is valid whenever the state is an emitting state.
  - State and counter advance only on cycles with tx_wen=1.
  - While tx_fifo_full=1 the block holds state, counter and tx_wdata unchanged.
  - tx_wen and tx_wdata are combinational from state, cnt, shift_reg and tx_fifo_full.
  - tx_wen is never high in IDLE or DONE.
- Latency, no backpressure:
  - Start sampled at cycle 0; first tx_wen at cycle 1.
  - Data mode: last byte at cycle 19, flushing_wq at cycle 20, back in IDLE at cycle 21.
  - PC mode: flushing_wq at cycle 11.
- Each backpressure cycle delays every later event by exactly one cycle.
- Counter is 3 bits, counts 0..7, and wraps to 0 on the transition out of HEX0/HEX1.
- rdata_snd changing after start has no effect on the line being sent.
- Reset mid-line: async return to IDLE, all outputs 0 immediately, no flushing_wq pulse. A partial line left in the FIFO is acceptable.
- A start pulse in the same cycle as the DONE pulse is ignored. The dump logic only restarts after seeing flushing_wq.

Test Plan:
- Data mode, no backpressure: start with rdata_snd=64'h89ABCDEF_01234567, sel=0 -> bytes "01234567 89abcdef\r\n" on cycles 1-19; flushing_wq high only at cycle 20; snd_busy high for cycles 1-20.
- PC mode: start with rdata_snd=64'hFFFF_FFFF_0000_1A2C, sel=1 -> bytes "00001a2c\r\n"; flushing_wq at cycle 11; upper word ignored.
- Backpressure: tx_fifo_full high on cycles 3-5 during the data-mode run above -> tx_wen low on cycles 3-5; the third byte '2' (0x32) is held stable on tx_wdata and written at cycle 6; flushing_wq at cycle 23; no byte duplicated or lost.
- Ignored start: second rdata_snd_start with different data at cycle 8 -> output identical to the first line; no extra flushing_wq.
- HEX_UPPER=1, data 64'hFEDCBA98_76543210 -> "76543210 FEDCBA98\r\n".
- Reset mid-line: rst_n asserted at cycle 10 -> tx_wen, flushing_wq and snd_busy go to 0 immediately; after release, a new start sends a complete line correctly.
